// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, default field widths and
// a helper to pull the type field out of a {type, payload} flit.
package noc_pkg;

  localparam int NOC_TYPE_W = 2;
  localparam int NOC_DATA_W = 64;
  localparam int NOC_VCH_W  = 1;

  typedef enum logic [NOC_TYPE_W-1:0] {
    FT_NONE = 2'd0,
    FT_HEAD = 2'd1,
    FT_DATA = 2'd2,
    FT_TAIL = 2'd3
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [NOC_TYPE_W+NOC_DATA_W-1:0] flit);
    return flit_type_e'(flit[NOC_TYPE_W+NOC_DATA_W-1 -: NOC_TYPE_W]);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit storage with wrap-around pointers and a registered head output.
// The caller guarantees no read when empty and no write when full without a read.
module flit_fifo #(
  parameter int W     = 67,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, valid_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CW'(1);
    end
    // Head is taken from the post-write array so a write into an empty FIFO shows next cycle.
    head_d  = mem_d[rd_ptr_d];
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = valid_q;
  assign count      = count_q;
  assign full       = (count_q == CW'(DEPTH));

endmodule

// File: rtl/input_buffer.sv
// Per-port input buffer: packet-framing filter, credit return and sticky error
// in front of a flit FIFO that feeds one router output mux input.
//
// state   | meaning
// IDLE    | between packets, only HEAD is accepted
// BODY    | inside a packet, DATA/TAIL/HEAD accepted
module input_buffer
  import noc_pkg::*;
#(
  parameter int DATA_W = NOC_DATA_W,
  parameter int TYPE_W = NOC_TYPE_W,
  parameter int VCH_W  = NOC_VCH_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TYPE_W+DATA_W-1:0]  idata,
  input  logic                      ivalid,
  input  logic [VCH_W-1:0]          ivch,
  output logic [1:0]                ocredit,
  output logic [TYPE_W+DATA_W-1:0]  odata,
  output logic                      ovalid,
  output logic [VCH_W-1:0]          ovch,
  input  logic                      iready,
  output logic                      perr,
  output logic [$clog2(DEPTH):0]    ocount
);

  localparam int FW = TYPE_W + DATA_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        ocredit_q, ocredit_d;
  logic              perr_q, perr_d;

  flit_type_e        in_type;
  logic              deq;
  logic              wr_en;
  logic              drop_cred;
  logic              err;
  logic              fifo_full;
  logic              fifo_valid;
  logic [FW+VCH_W-1:0] fifo_head;

  assign in_type = flit_type(idata);
  assign deq     = fifo_valid && iready;

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    drop_cred = 1'b0;
    err       = 1'b0;
    if (ivalid) begin
      if (in_type == FT_NONE) begin
        drop_cred = 1'b1;
      end else if (state_q == ST_IDLE && in_type != FT_HEAD) begin
        drop_cred = 1'b1;
        err       = 1'b1;
      end else if (fifo_full && !deq) begin
        // Overflow means upstream ignored credits; no credit comes back for it.
        err = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (state_q == ST_BODY && in_type == FT_HEAD) begin
          err = 1'b1;
        end
        state_d = (in_type == FT_TAIL) ? ST_IDLE : ST_BODY;
      end
    end
    ocredit_d = {1'b0, deq} + {1'b0, drop_cred};
    perr_d    = perr_q | err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ocredit_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ocredit_q <= ocredit_d;
      perr_q    <= perr_d;
    end
  end

  flit_fifo #(
    .W     (FW + VCH_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    ({ivch, idata}),
    .rd_en      (deq),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (ocount),
    .full       (fifo_full)
  );

  assign odata   = fifo_head[FW-1:0];
  assign ovch    = fifo_head[FW +: VCH_W];
  assign ovalid  = fifo_valid;
  assign ocredit = ocredit_q;
  assign perr    = perr_q;

endmodule

// File: doc/input_buffer.md
# input_buffer

Per-port flit buffer that sits directly upstream of the router output `mux` and drives one of its `idata_N / ivalid_N / ivch_N` input triplets. It accepts flits from the link under credit-based flow control, stores up to `DEPTH` flits with their virtual-channel tag, and presents the oldest flit to the mux until the downstream arbiter acknowledges it. A small packet-framing checker drops malformed flits and flags protocol errors, so the mux only ever sees well-formed HEAD/DATA/TAIL sequences.

## Interface
- `DATA_W`, 64, payload width; the flit is `{type, payload}`.
- `TYPE_W`, 2, flit type field width; encodings NONE=0, HEAD=1, DATA=2, TAIL=3.
- `VCH_W`, 1, virtual-channel tag width.
- `DEPTH`, 4, FIFO depth; power of two, ≥2.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `idata` in TYPE_W+DATA_W: flit from link.
- `ivalid` in 1: flit on `idata` is present this cycle.
- `ivch` in VCH_W: VC tag of incoming flit.
- `ocredit` out 2: number of slots returned to upstream this cycle (0..2).
- `odata` out TYPE_W+DATA_W: head-of-FIFO flit, to mux `idata_N`.
- `ovalid` out 1: `odata` valid, to mux `ivalid_N`.
- `ovch` out VCH_W: VC tag of head flit, to mux `ivch_N`.
- `iready` in 1: downstream consumes head flit this cycle (arbiter grant to this port).
- `perr` out 1: sticky protocol/overflow error.
- `ocount` out log2(DEPTH)+1: current occupancy.

## Operation
- Upstream starts with DEPTH credits; it sends only when holding a credit.
- Framing FSM on the input side, states IDLE, BODY:
  - IDLE + HEAD → enqueue, go BODY.
  - IDLE + DATA/TAIL → drop, set `perr`, stay IDLE.
  - BODY + DATA → enqueue, stay BODY.
  - BODY + TAIL → enqueue, go IDLE.
  - BODY + HEAD → enqueue, set `perr`, stay BODY (truncated packet; new packet begins).
  - any state + NONE with `ivalid` → drop silently, no error, state unchanged.
- Dropped flits return their credit immediately so the upstream count stays consistent.
- Dequeue when `ovalid && iready`; `iready` with `ovalid`=0 is ignored.
- Overflow: enqueue-eligible flit arrives while full with no dequeue that cycle → drop, set `perr`, no credit returned (an upstream bug; counts are already inconsistent).
- Full with simultaneous dequeue: the write is accepted and occupancy is unchanged.
- `ocredit` = dequeue(0/1) + dropped-and-credited(0/1), registered.
- `perr` clears only on reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter is one bit wider.

## Timing
- Reset values: `odata`=0, `ovalid`=0, `ovch`=0, `ocredit`=0, `perr`=0, `ocount`=0, FSM=IDLE, pointers=0.
- Reset mid-packet: the FIFO empties, FSM returns to IDLE, and in-flight credits are lost; upstream must reset together with this block.
- Write-to-output latency is 1 cycle. A flit accepted at edge k shows `ovalid`=1 after edge k if the FIFO was empty. There is no same-cycle bypass.
- `odata/ovalid/ovch` are registered from FIFO head and change only on edges.
- Back-to-back dequeues at one flit per cycle are supported with no bubbles.
- `ocredit` asserts in the cycle after the dequeue or drop edge, for one cycle per event.
- `perr` rises the cycle after the offending flit.

## Structure
- Shared package `noc_pkg`: flit type encodings (NONE/HEAD/DATA/TAIL), `TYPE_W`, `DATA_W`, `VCH_W` defaults, and a flit-type extract function.
- One sub-module `flit_fifo` (storage, pointers, occupancy, full/empty). The framing FSM, credit logic and error flag sit in `input_buffer`.

## Test plan
- Reset, then HEAD, 20 DATA, TAIL back-to-back with `iready`=1 → all 22 flits appear in order 1 cycle later, `ocredit`=1 for 22 cycles, `perr`=0.
- `iready`=0 while 4 flits are sent (DEPTH=4) → `ocount`=4, `ocredit`=0. Then `iready`=1 for 4 cycles → flits drain in order, 4 credit pulses.
- Full FIFO, write and `iready` in the same cycle → `ocount` stays 4, new flit is last out, `ocredit`=1.
- DATA sent while FSM is IDLE → not enqueued, `ovalid` stays 0, `ocredit`=1 next cycle, `perr`=1 and stays set.
- HEAD, DATA, then HEAD without TAIL → all three enqueued, `perr`=1. With `iready`=1, a dequeue and a dropped NONE flit in the same cycle → `ocredit`=2.
- Assert `rst` mid-packet with 3 flits buffered → `ovalid`=0 and `ocount`=0 immediately. After release, a fresh HEAD is accepted without error.
